// File: rtl/a2d_spi_intf.sv
// SPI master for the 8-channel 12-bit A2D: one command frame, a one-SCLK-period gap,
// then one read frame whose low 12 bits become the conversion result.
module a2d_spi_intf #(
    parameter int unsigned SCLK_W     = 5,
    parameter int unsigned FRAME_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_conv,
    input  logic [2:0]  chnnl,
    output logic        cnv_cmplt,
    output logic [11:0] A2D_res,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int unsigned P  = 2 ** SCLK_W;
    localparam int unsigned CW = SCLK_W + 5;
    localparam logic [CW-1:0] SclkEnd  = CW'(FRAME_BITS * P);
    localparam logic [CW-1:0] FrameEnd = CW'(FRAME_BITS * P + P / 2);
    localparam logic [CW-1:0] GapEnd   = CW'(P);

    typedef enum logic [1:0] {StIdle, StFrm1, StGap, StFrm2} state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d, cnt_nxt;
    logic [FRAME_BITS-1:0]   tx_q, tx_d;
    logic [11:0]             rx_q, rx_d;
    logic [11:0]             res_q, res_d;
    logic                    cmplt_q, cmplt_d;
    logic                    ss_n_q, ss_n_d;
    logic                    sclk_q, sclk_d;
    logic                    mosi_q, mosi_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            res_q   <= '0;
            cmplt_q <= 1'b0;
            ss_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            res_q   <= res_d;
            cmplt_q <= cmplt_d;
            ss_n_q  <= ss_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        res_d   = res_q;
        cmplt_d = cmplt_q;
        ss_n_d  = ss_n_q;
        sclk_d  = 1'b1;
        mosi_d  = mosi_q;
        cnt_nxt = cnt_q + CW'(1);

        unique case (state_q)
            StIdle: begin
                mosi_d = 1'b0;
                if (start_conv) begin
                    state_d = StFrm1;
                    cnt_d   = '0;
                    ss_n_d  = 1'b0;
                    tx_d    = {2'b00, chnnl, 11'h000};
                    rx_d    = '0;
                    cmplt_d = 1'b0;
                end
            end
            StFrm1, StFrm2: begin
                cnt_d = cnt_nxt;
                if (cnt_nxt == FrameEnd) begin
                    ss_n_d = 1'b1;
                    mosi_d = 1'b0;
                    cnt_d  = '0;
                    if (state_q == StFrm1) begin
                        state_d = StGap;
                    end else begin
                        state_d = StIdle;
                        res_d   = rx_q;
                        cmplt_d = 1'b1;
                    end
                end else begin
                    // SCLK low in the second half of each period, for the first 16 periods only
                    sclk_d = !((cnt_nxt < SclkEnd) && cnt_nxt[SCLK_W-1]);
                    if (sclk_q && !sclk_d) begin
                        mosi_d = tx_q[FRAME_BITS-1];
                        tx_d   = tx_q << 1;
                    end
                    // Only 12 bits are kept; the upper 4 received bits fall off the top
                    if (!sclk_q && sclk_d) begin
                        rx_d = {rx_q[10:0], MISO};
                    end
                end
            end
            StGap: begin
                cnt_d = cnt_nxt;
                if (cnt_nxt == GapEnd) begin
                    state_d = StFrm2;
                    cnt_d   = '0;
                    ss_n_d  = 1'b0;
                    tx_d    = '0;
                    rx_d    = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign cnv_cmplt = cmplt_q;
    assign A2D_res   = res_q;
    assign SS_n      = ss_n_q;
    assign SCLK      = sclk_q;
    assign MOSI      = mosi_q;

endmodule

// File: tb/tb_a2d_spi_intf.sv
// Bench for a2d_spi_intf: an A2D slave model drives MISO, a bus monitor records each frame,
// and expectations come from the frame/latency arithmetic of the protocol.
module tb_a2d_spi_intf;

    localparam int P = 32;
    localparam int H = P / 2;
    localparam int LATENCY = 2 * (16 * P + H) + P + 1;

    logic        clk;
    logic        rst;
    logic        start_conv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] A2D_res;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    int errors = 0;
    int checks = 0;

    a2d_spi_intf #(.SCLK_W(5), .FRAME_BITS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_conv (start_conv),
        .chnnl      (chnnl),
        .cnv_cmplt  (cnv_cmplt),
        .A2D_res    (A2D_res),
        .SS_n       (SS_n),
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .MISO       (MISO)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave model and bus monitor
    logic [15:0] miso_word = 16'h0000;
    logic [15:0] cap = 16'h0000;
    int          rises = 0;
    int          bitk = 0;
    logic        ss_prev = 1'b1;
    logic        sclk_prev = 1'b1;
    logic [15:0] cmd_q[$];
    int          rise_q[$];
    int          gap_q[$];
    int          hi_run = 0;
    int          idle_toggles = 0;

    always @(SS_n or SCLK) begin
        if (SS_n !== ss_prev) begin
            if (SS_n === 1'b0) begin
                cap = 16'h0000;
                rises = 0;
                bitk = 0;
                gap_q.push_back(hi_run);
            end else if (SS_n === 1'b1) begin
                cmd_q.push_back(cap);
                rise_q.push_back(rises);
            end
        end
        if (SCLK !== sclk_prev && SS_n === 1'b0) begin
            if (SCLK === 1'b1) begin
                cap = {cap[14:0], MOSI};
                rises++;
            end else begin
                if (bitk < 16) MISO = miso_word[15 - bitk];
                bitk++;
            end
        end
        ss_prev = SS_n;
        sclk_prev = SCLK;
    end

    always @(negedge clk) begin
        if (SS_n === 1'b1) begin
            hi_run++;
            if (SCLK !== 1'b1) idle_toggles++;
        end else begin
            hi_run = 0;
        end
    end

    function automatic logic [15:0] exp_cmd(input logic [2:0] ch);
        return 16'(ch) << 11;
    endfunction

    task automatic clear_mon();
        cmd_q.delete();
        rise_q.delete();
        gap_q.delete();
    endtask

    // One conversion; lat counts clks with the accepting edge as clk 1
    task automatic run_conv(input logic [2:0] ch, input logic [15:0] word,
                            output int lat, output logic cmplt_at_accept);
        clear_mon();
        @(negedge clk);
        chnnl = ch;
        miso_word = word;
        start_conv = 1'b1;
        @(posedge clk);
        #1;
        start_conv = 1'b0;
        cmplt_at_accept = cnv_cmplt;
        lat = 1;
        while (cnv_cmplt !== 1'b1 && lat < 3000) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_conv = 1'b1;
        chnnl = 3'd5;
        MISO = 1'b0;
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (SS_n !== 1'b1 || SCLK !== 1'b1 || cnv_cmplt !== 1'b0 || A2D_res !== 12'h000 ||
                MOSI !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: SS_n=%b SCLK=%b cmplt=%b res=%h MOSI=%b, want 1 1 0 000 0",
                         SS_n, SCLK, cnv_cmplt, A2D_res, MOSI);
            end
        end
        start_conv = 1'b0;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (SS_n !== 1'b1 || idle_toggles != 0) begin
            errors++;
            $display("FAIL reset_idle: SS_n=%b idle_toggles=%0d, want 1 and 0", SS_n, idle_toggles);
        end
    endtask

    task automatic test_ch5();
        int   lat;
        logic c0;
        run_conv(3'd5, 16'hFABC, lat, c0);
        checks++;
        if (lat != LATENCY) begin
            errors++;
            $display("FAIL ch5_latency: got %0d clks, want %0d", lat, LATENCY);
        end
        checks++;
        if (A2D_res !== 12'hABC || cnv_cmplt !== 1'b1) begin
            errors++;
            $display("FAIL ch5_result: res=%h cmplt=%b, want abc 1", A2D_res, cnv_cmplt);
        end
        checks++;
        if (cmd_q.size() != 2 || cmd_q[0] !== 16'h2800 || cmd_q[1] !== 16'h0000) begin
            errors++;
            $display("FAIL ch5_mosi: frames=%0d f1=%h f2=%h, want 2 2800 0000",
                     cmd_q.size(), cmd_q.size() > 0 ? cmd_q[0] : 16'hxxxx,
                     cmd_q.size() > 1 ? cmd_q[1] : 16'hxxxx);
        end
        checks++;
        if (rise_q.size() != 2 || rise_q[0] != 16 || rise_q[1] != 16) begin
            errors++;
            $display("FAIL ch5_rises: frames=%0d, want 2 frames of 16 rises", rise_q.size());
        end
        checks++;
        if (gap_q.size() != 2 || gap_q[1] != P) begin
            errors++;
            $display("FAIL ch5_gap: got %0d clks high, want %0d",
                     gap_q.size() > 1 ? gap_q[1] : -1, P);
        end
    endtask

    task automatic test_sweep();
        int          lat;
        logic        c0;
        logic [15:0] word;
        for (int ch = 0; ch < 8; ch++) begin
            word = {4'($urandom), 3'(ch), 9'h1A5};
            run_conv(3'(ch), word, lat, c0);
            checks++;
            if (c0 !== 1'b0) begin
                errors++;
                $display("FAIL sweep_clear ch%0d: cmplt=%b after accept, want 0", ch, c0);
            end
            checks++;
            if (cmd_q.size() < 1 || cmd_q[0] !== exp_cmd(3'(ch))) begin
                errors++;
                $display("FAIL sweep_cmd ch%0d: got %h, want %h", ch,
                         cmd_q.size() > 0 ? cmd_q[0] : 16'hxxxx, exp_cmd(3'(ch)));
            end
            checks++;
            if (A2D_res !== word[11:0] || lat != LATENCY) begin
                errors++;
                $display("FAIL sweep_res ch%0d: res=%h lat=%0d, want %h %0d", ch, A2D_res, lat,
                         word[11:0], LATENCY);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  chs[3];
        logic [15:0] words[3];
        int          seen = 0;
        int          n = 0;
        for (int i = 0; i < 3; i++) begin
            chs[i] = 3'($urandom_range(0, 7));
            words[i] = 16'($urandom);
        end
        clear_mon();
        @(negedge clk);
        chnnl = chs[0];
        miso_word = words[0];
        start_conv = 1'b1;
        while (seen < 3 && n < 5000) begin
            @(negedge clk);
            n++;
            if (cnv_cmplt === 1'b1) begin
                checks++;
                if (A2D_res !== words[seen][11:0]) begin
                    errors++;
                    $display("FAIL b2b_res #%0d: got %h, want %h", seen, A2D_res, words[seen][11:0]);
                end
                if (seen > 0) begin
                    checks++;
                    if (n != LATENCY) begin
                        errors++;
                        $display("FAIL b2b_period #%0d: got %0d clks, want %0d", seen, n, LATENCY);
                    end
                end
                n = 0;
                seen++;
                if (seen < 3) begin
                    chnnl = chs[seen];
                    miso_word = words[seen];
                end else begin
                    start_conv = 1'b0;
                end
                @(negedge clk);
                n++;
                checks++;
                if (cnv_cmplt !== (seen == 3)) begin
                    errors++;
                    $display("FAIL b2b_pulse #%0d: cmplt=%b one clk later, want %b", seen, cnv_cmplt,
                             seen == 3);
                end
            end
        end
        checks++;
        if (seen != 3) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d completions, want 3", seen);
        end
        repeat (1200) @(negedge clk);
        checks++;
        if (cmd_q.size() != 6) begin
            errors++;
            $display("FAIL b2b_frames: got %0d frames, want 6", cmd_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (cmd_q[2 * i] !== exp_cmd(chs[i]) || cmd_q[2 * i + 1] !== 16'h0000) begin
                    errors++;
                    $display("FAIL b2b_cmd #%0d: got %h/%h, want %h/0000", i, cmd_q[2 * i],
                             cmd_q[2 * i + 1], exp_cmd(chs[i]));
                end
            end
        end
    endtask

    task automatic test_midframe();
        logic [15:0] word;
        int          n = 0;
        word = 16'($urandom);
        clear_mon();
        @(negedge clk);
        chnnl = 3'd3;
        miso_word = word;
        start_conv = 1'b1;
        @(negedge clk);
        start_conv = 1'b0;
        repeat (100) @(negedge clk);
        chnnl = 3'd6;
        while (gap_q.size() < 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (100) @(negedge clk);
        start_conv = 1'b1;
        @(negedge clk);
        start_conv = 1'b0;
        while (cnv_cmplt !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_q.size() < 1 || cmd_q[0] !== 16'h1800 || A2D_res !== word[11:0]) begin
            errors++;
            $display("FAIL mid_chnnl: cmd=%h res=%h, want 1800 %h",
                     cmd_q.size() > 0 ? cmd_q[0] : 16'hxxxx, A2D_res, word[11:0]);
        end
        repeat (1200) @(negedge clk);
        checks++;
        if (cmd_q.size() != 2 || cnv_cmplt !== 1'b1 || SS_n !== 1'b1) begin
            errors++;
            $display("FAIL mid_ignored: frames=%0d cmplt=%b SS_n=%b, want 2 1 1",
                     cmd_q.size(), cnv_cmplt, SS_n);
        end
    endtask

    task automatic test_reset_midframe();
        int          n = 0;
        int          lat;
        logic        c0;
        logic [15:0] word;
        clear_mon();
        @(negedge clk);
        chnnl = 3'($urandom_range(0, 7));
        miso_word = 16'($urandom);
        start_conv = 1'b1;
        @(negedge clk);
        start_conv = 1'b0;
        while (gap_q.size() < 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (50) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (SS_n !== 1'b1 || SCLK !== 1'b1 || A2D_res !== 12'h000 || cnv_cmplt !== 1'b0 ||
            MOSI !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_now: SS_n=%b SCLK=%b res=%h cmplt=%b MOSI=%b, want 1 1 000 0 0",
                     SS_n, SCLK, A2D_res, cnv_cmplt, MOSI);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (1200) @(negedge clk);
        checks++;
        if (SS_n !== 1'b1 || A2D_res !== 12'h000 || cnv_cmplt !== 1'b0 || idle_toggles != 0) begin
            errors++;
            $display("FAIL rstmid_after: SS_n=%b res=%h cmplt=%b toggles=%0d, want 1 000 0 0",
                     SS_n, A2D_res, cnv_cmplt, idle_toggles);
        end
        word = 16'($urandom);
        run_conv(3'd2, word, lat, c0);
        checks++;
        if (A2D_res !== word[11:0] || lat != LATENCY || cmd_q.size() != 2 ||
            cmd_q[0] !== exp_cmd(3'd2)) begin
            errors++;
            $display("FAIL rstmid_clean: res=%h lat=%0d frames=%0d, want %h %0d 2",
                     A2D_res, lat, cmd_q.size(), word[11:0], LATENCY);
        end
    endtask

    initial begin
        rst = 1'b1;
        start_conv = 1'b0;
        chnnl = 3'd0;
        MISO = 1'b0;
        test_reset();
        test_ch5();
        test_sweep();
        test_back_to_back();
        test_midframe();
        test_reset_midframe();
        checks++;
        if (idle_toggles != 0) begin
            errors++;
            $display("FAIL idle_sclk: SCLK low while SS_n high %0d times, want 0", idle_toggles);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
